etapa_id_ex: RTL and testbench

ETAPA_ID_EX -- requirements
Module: etapa_id_ex

---
 rtl/etapa_id_ex.sv | 147 ++++++++++++++
 tb/tb_etapa_id_ex.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/etapa_id_ex.sv
// ID/EX pipeline register with ALU operation decode and EX/MEM, MEM/WB operand forwarding.
// Operands are resolved combinationally from the registered specifiers, so forwarding stays live while stalled.
module etapa_id_ex (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] DATO_RS,
  input  logic [31:0] DATO_RT,
  input  logic [15:0] INMEDIATO,
  input  logic [4:0]  RS,
  input  logic [4:0]  RT,
  input  logic [4:0]  RD,
  input  logic [1:0]  ALUOP,
  input  logic [5:0]  FUNCT,
  input  logic        ALUSRC,
  input  logic        REGDST,
  input  logic        REGWRITE,
  input  logic        EXMEM_REGWRITE,
  input  logic [4:0]  EXMEM_RD,
  input  logic [31:0] EXMEM_RESULTADO,
  input  logic        MEMWB_REGWRITE,
  input  logic [4:0]  MEMWB_RD,
  input  logic [31:0] MEMWB_DATO,
  output logic [31:0] OPERADOR1,
  output logic [31:0] OPERADOR2,
  output logic [2:0]  SEL,
  output logic [31:0] DATO_ESCRITURA,
  output logic [4:0]  RD_EX,
  output logic        REGWRITE_EX,
  output logic        VALIDO
);

  localparam logic [2:0] SEL_AND  = 3'b000;
  localparam logic [2:0] SEL_OR   = 3'b001;
  localparam logic [2:0] SEL_ADD  = 3'b010;
  localparam logic [2:0] SEL_ZERO = 3'b011;
  localparam logic [2:0] SEL_NOR  = 3'b100;
  localparam logic [2:0] SEL_SUB  = 3'b110;
  localparam logic [2:0] SEL_SLT  = 3'b111;

  logic [31:0] dato_rs_r;
  logic [31:0] dato_rt_r;
  logic [31:0] inmediato_r;
  logic [4:0]  rs_r;
  logic [4:0]  rt_r;
  logic [4:0]  rd_r;
  logic [2:0]  sel_r;
  logic        alusrc_r;
  logic        regwrite_r;
  logic        valido_r;

  logic [31:0] operador1_s;
  logic [31:0] operador2_s;
  logic [31:0] dato_escritura_s;

  function automatic logic [2:0] decode_funct(input logic [5:0] funct);
    case (funct)
      6'b100000: decode_funct = SEL_ADD;
      6'b100010: decode_funct = SEL_SUB;
      6'b100100: decode_funct = SEL_AND;
      6'b100101: decode_funct = SEL_OR;
      6'b101010: decode_funct = SEL_SLT;
      6'b100111: decode_funct = SEL_NOR;
      default:   decode_funct = SEL_ZERO;
    endcase
  endfunction

  function automatic logic [2:0] decode_sel(input logic [1:0] aluop, input logic [5:0] funct);
    case (aluop)
      2'b00:   decode_sel = SEL_ADD;
      2'b01:   decode_sel = SEL_SUB;
      2'b10:   decode_sel = decode_funct(funct);
      2'b11:   decode_sel = SEL_OR;
      default: decode_sel = SEL_ZERO;
    endcase
  endfunction

  // Register 0 is hardwired, so a producer targeting it never overrides the operand.
  function automatic logic [31:0] forward(
    input logic [4:0]  spec,
    input logic [31:0] reg_val,
    input logic        exmem_rw,
    input logic [4:0]  exmem_rd,
    input logic [31:0] exmem_val,
    input logic        memwb_rw,
    input logic [4:0]  memwb_rd,
    input logic [31:0] memwb_val
  );
    if (exmem_rw && (exmem_rd != 5'd0) && (exmem_rd == spec)) begin
      forward = exmem_val;
    end else if (memwb_rw && (memwb_rd != 5'd0) && (memwb_rd == spec)) begin
      forward = memwb_val;
    end else begin
      forward = reg_val;
    end
  endfunction

  // Pipeline slot update: reset and flush load a bubble, stall holds, otherwise load decode.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      dato_rs_r   <= 32'd0;
      dato_rt_r   <= 32'd0;
      inmediato_r <= 32'd0;
      rs_r        <= 5'd0;
      rt_r        <= 5'd0;
      rd_r        <= 5'd0;
      sel_r       <= SEL_ZERO;
      alusrc_r    <= 1'b0;
      regwrite_r  <= 1'b0;
      valido_r    <= 1'b0;
    end else if (!STALL) begin
      dato_rs_r   <= DATO_RS;
      dato_rt_r   <= DATO_RT;
      inmediato_r <= {{16{INMEDIATO[15]}}, INMEDIATO};
      rs_r        <= RS;
      rt_r        <= RT;
      rd_r        <= REGDST ? RD : RT;
      sel_r       <= decode_sel(ALUOP, FUNCT);
      alusrc_r    <= ALUSRC;
      regwrite_r  <= REGWRITE;
      valido_r    <= 1'b1;
    end
  end

  // Operand resolution from the registered specifiers and live forwarding buses.
  always_comb begin
    operador1_s      = forward(rs_r, dato_rs_r, EXMEM_REGWRITE, EXMEM_RD, EXMEM_RESULTADO,
                               MEMWB_REGWRITE, MEMWB_RD, MEMWB_DATO);
    dato_escritura_s = forward(rt_r, dato_rt_r, EXMEM_REGWRITE, EXMEM_RD, EXMEM_RESULTADO,
                               MEMWB_REGWRITE, MEMWB_RD, MEMWB_DATO);
    if (alusrc_r) begin
      operador2_s = inmediato_r;
    end else begin
      operador2_s = dato_escritura_s;
    end
  end

  assign OPERADOR1      = operador1_s;
  assign OPERADOR2      = operador2_s;
  assign DATO_ESCRITURA = dato_escritura_s;
  assign SEL            = sel_r;
  assign RD_EX          = rd_r;
  assign REGWRITE_EX    = regwrite_r;
  assign VALIDO         = valido_r;

endmodule

// File: tb/tb_etapa_id_ex.sv
// Table-driven bench for etapa_id_ex: decode, forwarding, stall, flush and reset vectors,
// plus a hand-written stall/reset-mid-stall sequence.
module tb_etapa_id_ex;

  logic        CLK = 1'b0;
  logic        RST, STALL, FLUSH;
  logic [31:0] DATO_RS, DATO_RT;
  logic [15:0] INMEDIATO;
  logic [4:0]  RS, RT, RD;
  logic [1:0]  ALUOP;
  logic [5:0]  FUNCT;
  logic        ALUSRC, REGDST, REGWRITE;
  logic        EXMEM_REGWRITE;
  logic [4:0]  EXMEM_RD;
  logic [31:0] EXMEM_RESULTADO;
  logic        MEMWB_REGWRITE;
  logic [4:0]  MEMWB_RD;
  logic [31:0] MEMWB_DATO;
  logic [31:0] OPERADOR1, OPERADOR2, DATO_ESCRITURA;
  logic [2:0]  SEL;
  logic [4:0]  RD_EX;
  logic        REGWRITE_EX, VALIDO;

  etapa_id_ex dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .DATO_RS(DATO_RS), .DATO_RT(DATO_RT), .INMEDIATO(INMEDIATO),
    .RS(RS), .RT(RT), .RD(RD), .ALUOP(ALUOP), .FUNCT(FUNCT),
    .ALUSRC(ALUSRC), .REGDST(REGDST), .REGWRITE(REGWRITE),
    .EXMEM_REGWRITE(EXMEM_REGWRITE), .EXMEM_RD(EXMEM_RD), .EXMEM_RESULTADO(EXMEM_RESULTADO),
    .MEMWB_REGWRITE(MEMWB_REGWRITE), .MEMWB_RD(MEMWB_RD), .MEMWB_DATO(MEMWB_DATO),
    .OPERADOR1(OPERADOR1), .OPERADOR2(OPERADOR2), .SEL(SEL),
    .DATO_ESCRITURA(DATO_ESCRITURA), .RD_EX(RD_EX), .REGWRITE_EX(REGWRITE_EX), .VALIDO(VALIDO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, stall, flush;
    logic [31:0] dato_rs, dato_rt;
    logic [15:0] inm;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        alusrc, regdst, regwrite;
    logic        ex_rw;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        mw_rw;
    logic [4:0]  mw_rd;
    logic [31:0] mw_dato;
    logic [31:0] e_op1, e_op2, e_wdata;
    logic [2:0]  e_sel;
    logic [4:0]  e_rd;
    logic        e_rw, e_val;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t expect_out(input vec_t v, input logic [31:0] op1, input logic [31:0] op2,
                                      input logic [31:0] wd, input logic [2:0] sel,
                                      input logic [4:0] rd, input logic rw, input logic val);
    vec_t r;
    r = v;
    r.e_op1 = op1; r.e_op2 = op2; r.e_wdata = wd; r.e_sel = sel;
    r.e_rd = rd; r.e_rw = rw; r.e_val = val;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                           input logic [31:0] wd, input logic [2:0] sel, input logic [4:0] rd,
                           input logic rw, input logic val);
    check({tag, ".op1"},   OPERADOR1,      op1);
    check({tag, ".op2"},   OPERADOR2,      op2);
    check({tag, ".wdata"}, DATO_ESCRITURA, wd);
    check({tag, ".sel"},   {29'd0, SEL},   {29'd0, sel});
    check({tag, ".rd"},    {27'd0, RD_EX}, {27'd0, rd});
    check({tag, ".rw"},    {31'd0, REGWRITE_EX}, {31'd0, rw});
    check({tag, ".valid"}, {31'd0, VALIDO},      {31'd0, val});
  endtask

  task automatic apply(input vec_t v);
    RST = v.rst; STALL = v.stall; FLUSH = v.flush;
    DATO_RS = v.dato_rs; DATO_RT = v.dato_rt; INMEDIATO = v.inm;
    RS = v.rs; RT = v.rt; RD = v.rd; ALUOP = v.aluop; FUNCT = v.funct;
    ALUSRC = v.alusrc; REGDST = v.regdst; REGWRITE = v.regwrite;
    EXMEM_REGWRITE = v.ex_rw; EXMEM_RD = v.ex_rd; EXMEM_RESULTADO = v.ex_res;
    MEMWB_REGWRITE = v.mw_rw; MEMWB_RD = v.mw_rd; MEMWB_DATO = v.mw_dato;
  endtask

  initial begin
    vec_t v, base, f;
    logic [5:0] fl [7];
    logic [2:0] fs [7];

    fl[0] = 6'b000000; fs[0] = 3'b011;
    fl[1] = 6'b101010; fs[1] = 3'b111;
    fl[2] = 6'b100100; fs[2] = 3'b000;
    fl[3] = 6'b100101; fs[3] = 3'b001;
    fl[4] = 6'b100111; fs[4] = 3'b100;
    fl[5] = 6'b100000; fs[5] = 3'b010;
    fl[6] = 6'b111111; fs[6] = 3'b011;

    base = '{default: '0};

    // Reset bubble
    v = base; v.rst = 1'b1; v.stall = 1'b1; v.dato_rs = 32'h5; v.rs = 5'd3;
    tbl.push_back(expect_out(v, 32'd0, 32'd0, 32'd0, 3'b011, 5'd0, 1'b0, 1'b0));

    // R-type SUB, destination RD
    v = base; v.aluop = 2'b10; v.funct = 6'b100010; v.dato_rs = 32'd9; v.dato_rt = 32'd4;
    v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd3; v.regdst = 1'b1; v.regwrite = 1'b1;
    tbl.push_back(expect_out(v, 32'd9, 32'd4, 32'd4, 3'b110, 5'd3, 1'b1, 1'b1));

    // Negative immediate, destination RT
    v = base; v.aluop = 2'b00; v.alusrc = 1'b1; v.inm = 16'hFFFC; v.rt = 5'd7; v.rd = 5'd9;
    v.dato_rs = 32'h11; v.dato_rt = 32'h22; v.regwrite = 1'b1;
    tbl.push_back(expect_out(v, 32'h11, 32'hFFFFFFFC, 32'h22, 3'b010, 5'd7, 1'b1, 1'b1));

    // FUNCT decode sweep
    f = base; f.aluop = 2'b10; f.rs = 5'd3; f.rt = 5'd4; f.rd = 5'd5; f.regdst = 1'b1;
    f.dato_rs = 32'd1; f.dato_rt = 32'd2;
    for (int i = 0; i < 7; i++) begin
      v = f; v.funct = fl[i];
      tbl.push_back(expect_out(v, 32'd1, 32'd2, 32'd2, fs[i], 5'd5, 1'b0, 1'b1));
    end
    v = f; v.aluop = 2'b11; v.funct = 6'b100000;
    tbl.push_back(expect_out(v, 32'd1, 32'd2, 32'd2, 3'b001, 5'd5, 1'b0, 1'b1));
    v = f; v.aluop = 2'b01; v.funct = 6'b100100;
    tbl.push_back(expect_out(v, 32'd1, 32'd2, 32'd2, 3'b110, 5'd5, 1'b0, 1'b1));
    v = f; v.aluop = 2'b00; v.alusrc = 1'b1; v.inm = 16'h7FFF;
    tbl.push_back(expect_out(v, 32'd1, 32'h00007FFF, 32'd2, 3'b010, 5'd5, 1'b0, 1'b1));

    // Forwarding: EX/MEM beats MEM/WB on the same specifier
    f = base; f.rs = 5'd5; f.rt = 5'd6; f.rd = 5'd8; f.regdst = 1'b1; f.regwrite = 1'b1;
    f.dato_rs = 32'h55; f.dato_rt = 32'h66;
    f.ex_rw = 1'b1; f.ex_rd = 5'd5; f.ex_res = 32'hAA;
    f.mw_rw = 1'b1; f.mw_rd = 5'd5; f.mw_dato = 32'hBB;
    tbl.push_back(expect_out(f, 32'hAA, 32'h66, 32'h66, 3'b010, 5'd8, 1'b1, 1'b1));
    // Stalled: drop EX/MEM write -> MEM/WB value; decode inputs ignored
    v = f; v.stall = 1'b1; v.ex_rw = 1'b0; v.dato_rs = 32'h77; v.rs = 5'd9; v.rd = 5'd1;
    tbl.push_back(expect_out(v, 32'hBB, 32'h66, 32'h66, 3'b010, 5'd8, 1'b1, 1'b1));
    // Stalled: EX/MEM feeds RT while MEM/WB feeds RS
    v = f; v.stall = 1'b1; v.ex_rd = 5'd6; v.aluop = 2'b01;
    tbl.push_back(expect_out(v, 32'hBB, 32'hAA, 32'hAA, 3'b010, 5'd8, 1'b1, 1'b1));
    // Register 0 never forwarded
    v = base; v.dato_rs = 32'h12345678; v.dato_rt = 32'h9ABCDEF0; v.rd = 5'd4; v.regwrite = 1'b1;
    v.ex_rw = 1'b1; v.ex_res = 32'hAA; v.mw_rw = 1'b1; v.mw_dato = 32'hBB;
    tbl.push_back(expect_out(v, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 3'b010, 5'd0, 1'b1, 1'b1));
    // Matching specifiers with write enables low
    v = base; v.rs = 5'd7; v.rt = 5'd7; v.dato_rs = 32'd1; v.dato_rt = 32'd2;
    v.ex_rd = 5'd7; v.ex_res = 32'hAA; v.mw_rd = 5'd7; v.mw_dato = 32'hBB;
    tbl.push_back(expect_out(v, 32'd1, 32'd2, 32'd2, 3'b010, 5'd7, 1'b0, 1'b1));

    // Flush with stall, then reload and plain flush
    v = f; v.flush = 1'b1; v.stall = 1'b1; v.ex_rw = 1'b0; v.mw_rw = 1'b0;
    tbl.push_back(expect_out(v, 32'd0, 32'd0, 32'd0, 3'b011, 5'd0, 1'b0, 1'b0));
    v = f; v.ex_rw = 1'b0; v.mw_rw = 1'b0;
    tbl.push_back(expect_out(v, 32'h55, 32'h66, 32'h66, 3'b010, 5'd8, 1'b1, 1'b1));
    v = f; v.flush = 1'b1; v.ex_rw = 1'b0; v.mw_rw = 1'b0;
    tbl.push_back(expect_out(v, 32'd0, 32'd0, 32'd0, 3'b011, 5'd0, 1'b0, 1'b0));

    apply(base);
    RST = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      apply(tbl[i]);
      @(posedge CLK);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_op1, tbl[i].e_op2, tbl[i].e_wdata,
                tbl[i].e_sel, tbl[i].e_rd, tbl[i].e_rw, tbl[i].e_val);
    end

    // Hand sequence: load, hold through three stalls with changing inputs, reset mid-stall
    @(negedge CLK);
    apply(tbl[1]);
    @(posedge CLK);
    #1;
    check_all("seq.load", 32'd9, 32'd4, 32'd4, 3'b110, 5'd3, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      STALL = 1'b1;
      DATO_RS = $urandom; DATO_RT = $urandom; INMEDIATO = 16'($urandom);
      RS = 5'($urandom); RT = 5'($urandom); RD = 5'($urandom);
      ALUOP = 2'($urandom); FUNCT = 6'($urandom);
      ALUSRC = 1'b1; REGDST = 1'($urandom); REGWRITE = 1'b0;
      @(posedge CLK);
      #1;
      check_all($sformatf("seq.stall%0d", c), 32'd9, 32'd4, 32'd4, 3'b110, 5'd3, 1'b1, 1'b1);
    end
    EXMEM_REGWRITE = 1'b1; EXMEM_RD = 5'd1; EXMEM_RESULTADO = 32'hCAFE;
    #1;
    check("seq.stall_fwd.op1", OPERADOR1, 32'hCAFE);
    check("seq.stall_fwd.op2", OPERADOR2, 32'd4);
    EXMEM_REGWRITE = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_all("seq.rst_in_stall", 32'd0, 32'd0, 32'd0, 3'b011, 5'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
